wb_port_scheduler: RTL

//  Shares the register file's single write port among NREQ writeback sources (ALU, LSU, MUL/DIV)

---
 rtl/wb_port_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler
//   Shares the register-file write port among NREQ writeback sources with a
//   round-robin arbiter and drives the regfile from a one-deep registered
//   stage. Also holds the per-register busy scoreboard used by issue to
//   detect RAW/WAW hazards.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   -> byp1_hit/byp2_hit/byp_data forward the value sitting in the
//                  output stage, so issue does not wait for it to land in the
//                  regfile.
//     undefined -> no bypass ports; a source that matches the output stage
//                  stalls for one extra cycle.
module wb_port_scheduler #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           issue_rs1,
  input  logic [4:0]           issue_rs2,
  output logic                 stall,
  output logic [31:0]          busy
`ifdef WB_BYPASS_EN
  ,
  output logic                 byp1_hit,
  output logic                 byp2_hit,
  output logic [XLEN-1:0]      byp_data
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  logic [PW-1:0]   rr_q, rr_d;
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [31:0]     busy_q, busy_d;

  logic [4:0]      rd_arr   [NREQ];
  logic [XLEN-1:0] data_arr [NREQ];

  logic [PW-1:0]   scan_idx;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [4:0]      gnt_rd;
  logic [XLEN-1:0] gnt_data;

  logic            hz_busy;
  logic            pend1;
  logic            pend2;
  logic            issue_accept;

  // Split the flat requester buses into per-requester views.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rd_arr[g]   = req_rd[5*g +: 5];
    assign data_arr[g] = req_data[XLEN*g +: XLEN];
  end

  // Round-robin arbiter: scan upward from the pointer, first valid wins.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PW'((int'(rr_q) + k) % NREQ);
      if (!gnt_any && req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign gnt_rd   = rd_arr[gnt_idx];
  assign gnt_data = data_arr[gnt_idx];

  // Hazards are judged on state at the start of the cycle; a grant in this
  // same cycle does not release a stall until the next one.
  assign hz_busy = ((issue_rs1 != 5'd0) && busy_q[issue_rs1]) ||
                   ((issue_rs2 != 5'd0) && busy_q[issue_rs2]) ||
                   ((issue_rd  != 5'd0) && busy_q[issue_rd]);

  // Value still in the output stage, not yet written into the regfile.
  assign pend1 = we_q && (rd_q == issue_rs1) && (issue_rs1 != 5'd0);
  assign pend2 = we_q && (rd_q == issue_rs2) && (issue_rs2 != 5'd0);

`ifdef WB_BYPASS_EN
  assign stall    = issue_valid & hz_busy;
  assign byp1_hit = pend1;
  assign byp2_hit = pend2;
  assign byp_data = wdata_q;
`else
  assign stall    = issue_valid & (hz_busy | pend1 | pend2);
`endif

  assign issue_accept = issue_valid && !stall && (issue_rd != 5'd0);

  // Next-state: pointer advance, output stage load, scoreboard update.
  always_comb begin
    rr_d    = rr_q;
    we_d    = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    if (gnt_any) begin
      rr_d    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      we_d    = (gnt_rd != 5'd0);
      rd_d    = gnt_rd;
      wdata_d = gnt_data;
      if (gnt_rd != 5'd0) begin
        busy_d[gnt_rd] = 1'b0;
      end
    end
    // Applied after the clear so a new producer of the same register keeps it busy.
    if (issue_accept) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops any pending write and clears the scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_rd    = rd_q;
  assign rf_wdata = wdata_q;
  assign busy     = busy_q;

endmodule
